// File: rtl/instr_enc_pkg.sv
// Shared instruction-format definitions: field sizes and positions, opcode map and
// opcode-class predicates used by both the ID-stage decode and the encoder.
package instr_enc_pkg;

  localparam int SIZE_DATA  = 32;
  localparam int HBIT_DATA  = SIZE_DATA - 1;
  localparam int SIZE_ADDR  = 8;
  localparam int SIZE_OPC   = 6;
  localparam int SIZE_TGT_GP = 4;
  localparam int SIZE_TGT_SR = 3;
  localparam int SIZE_SRC_GP = 4;
  localparam int SIZE_SRC_SR = 3;
  localparam int SIZE_CC    = 4;
  localparam int SIZE_IMM   = 16;
  localparam int HBIT_IMM   = SIZE_IMM - 1;
  localparam int SIZE_IMMSR = 12;

  // Slots overlap between classes; no opcode uses two fields sharing a slot.
  localparam int LBIT_INSTR_OPC    = 26;
  localparam int LBIT_INSTR_TGT_GP = 22;
  localparam int LBIT_INSTR_TGT_SR = 22;
  localparam int LBIT_INSTR_CC     = 22;
  localparam int LBIT_INSTR_SRC_GP = 18;
  localparam int LBIT_INSTR_SRC_SR = 18;
  localparam int LBIT_INSTR_IMM    = 0;
  localparam int LBIT_INSTR_IMMSR  = 0;

  localparam logic [SIZE_OPC-1:0] OPC_NOP      = 6'd0;
  localparam logic [SIZE_OPC-1:0] OPC_R_ADD    = 6'd1;
  localparam logic [SIZE_OPC-1:0] OPC_R_MOV    = 6'd2;
  localparam logic [SIZE_OPC-1:0] OPC_I_ADDi   = 6'd3;
  localparam logic [SIZE_OPC-1:0] OPC_I_MOVi   = 6'd4;
  localparam logic [SIZE_OPC-1:0] OPC_I_LDi    = 6'd5;
  localparam logic [SIZE_OPC-1:0] OPC_IS_ADDis = 6'd6;
  localparam logic [SIZE_OPC-1:0] OPC_IS_BRA   = 6'd7;
  localparam logic [SIZE_OPC-1:0] OPC_S_LUI    = 6'd8;
  localparam logic [SIZE_OPC-1:0] OPC_S_SRJCC  = 6'd9;
  localparam logic [SIZE_OPC-1:0] OPC_S_MOVSR  = 6'd10;
  localparam logic [SIZE_OPC-1:0] OPC_S_MOVRS  = 6'd11;

  typedef enum logic [1:0] {ST_IDLE, ST_LUI, ST_MAIN} enc_st_e;

  typedef struct packed {
    logic [SIZE_OPC-1:0]    opc;
    logic [SIZE_TGT_GP-1:0] tgt_gp;
    logic [SIZE_TGT_SR-1:0] tgt_sr;
    logic [SIZE_SRC_GP-1:0] src_gp;
    logic [SIZE_SRC_SR-1:0] src_sr;
    logic [SIZE_CC-1:0]     cc;
    logic [SIZE_DATA-1:0]   imm;
    logic [SIZE_IMMSR-1:0]  immsr;
  } enc_req_t;

  typedef struct packed {
    logic                 expand;
    logic [SIZE_DATA-1:0] lui_word;
    logic [SIZE_DATA-1:0] word;
  } enc_ent_t;

  function automatic logic imm_en(input logic [SIZE_OPC-1:0] opc);
    return opc inside {OPC_I_ADDi, OPC_I_MOVi, OPC_I_LDi, OPC_IS_ADDis, OPC_IS_BRA, OPC_S_LUI};
  endfunction

  function automatic logic sgn_en(input logic [SIZE_OPC-1:0] opc);
    return opc inside {OPC_IS_ADDis, OPC_IS_BRA};
  endfunction

  function automatic logic is_branch(input logic [SIZE_OPC-1:0] opc);
    return opc inside {OPC_IS_BRA, OPC_S_SRJCC};
  endfunction

  function automatic logic has_immsr(input logic [SIZE_OPC-1:0] opc);
    return opc == OPC_S_SRJCC;
  endfunction

  function automatic logic has_tgt_gp(input logic [SIZE_OPC-1:0] opc);
    return opc inside {OPC_R_ADD, OPC_R_MOV, OPC_I_ADDi, OPC_I_MOVi, OPC_I_LDi,
                       OPC_IS_ADDis, OPC_S_MOVRS};
  endfunction

  function automatic logic has_tgt_sr(input logic [SIZE_OPC-1:0] opc);
    return opc == OPC_S_MOVSR;
  endfunction

  function automatic logic has_src_gp(input logic [SIZE_OPC-1:0] opc);
    return opc inside {OPC_R_ADD, OPC_R_MOV, OPC_S_MOVSR};
  endfunction

  function automatic logic has_src_sr(input logic [SIZE_OPC-1:0] opc);
    return opc == OPC_S_MOVRS;
  endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational field packer: request -> main word, companion LUI word, expand flag.
// INSTR_ENC_CHECK_EN adds the err output flagging unused/unrepresentable fields.
module instr_enc_pack
  import instr_enc_pkg::*;
(
  input  enc_req_t req,
  output enc_ent_t ent
`ifdef INSTR_ENC_CHECK_EN
  ,
  output logic     err
`endif
);

  logic [SIZE_DATA-1:0] word;
  logic [SIZE_DATA-1:0] lui_word;

  always_comb begin
    word = '0;
    word[LBIT_INSTR_OPC +: SIZE_OPC] = req.opc;
    if (has_tgt_gp(req.opc)) word[LBIT_INSTR_TGT_GP +: SIZE_TGT_GP] = req.tgt_gp;
    if (has_tgt_sr(req.opc)) word[LBIT_INSTR_TGT_SR +: SIZE_TGT_SR] = req.tgt_sr;
    if (has_src_gp(req.opc)) word[LBIT_INSTR_SRC_GP +: SIZE_SRC_GP] = req.src_gp;
    if (has_src_sr(req.opc)) word[LBIT_INSTR_SRC_SR +: SIZE_SRC_SR] = req.src_sr;
    if (is_branch(req.opc))  word[LBIT_INSTR_CC +: SIZE_CC]         = req.cc;
    if (imm_en(req.opc))     word[LBIT_INSTR_IMM +: SIZE_IMM]       = req.imm[HBIT_IMM:0];
    if (has_immsr(req.opc))  word[LBIT_INSTR_IMMSR +: SIZE_IMMSR]   = req.immsr;
  end

  always_comb begin
    lui_word = '0;
    lui_word[LBIT_INSTR_OPC +: SIZE_OPC] = OPC_S_LUI;
    lui_word[LBIT_INSTR_IMM +: SIZE_IMM] = req.imm[HBIT_DATA:SIZE_IMM];
  end

  // Only unsigned I-class immediates with upper bits set need the LUI prefix.
  assign ent.expand   = imm_en(req.opc) && !sgn_en(req.opc) && (req.opc != OPC_S_LUI) &&
                        (|req.imm[HBIT_DATA:SIZE_IMM]);
  assign ent.lui_word = lui_word;
  assign ent.word     = word;

`ifdef INSTR_ENC_CHECK_EN
  logic unused_nz, sgn_bad;
  assign unused_nz = (!has_tgt_gp(req.opc) && |req.tgt_gp) ||
                     (!has_tgt_sr(req.opc) && |req.tgt_sr) ||
                     (!has_src_gp(req.opc) && |req.src_gp) ||
                     (!has_src_sr(req.opc) && |req.src_sr) ||
                     (!is_branch(req.opc)  && |req.cc)     ||
                     (!imm_en(req.opc)     && |req.imm)    ||
                     (!has_immsr(req.opc)  && |req.immsr);
  assign sgn_bad   = sgn_en(req.opc) &&
                     !((&req.imm[HBIT_DATA:HBIT_IMM]) || !(|req.imm[HBIT_DATA:HBIT_IMM]));
  assign err       = unused_nz || sgn_bad;
`endif

endmodule

// File: rtl/instr_enc.sv
// Instruction encoder: request FIFO of packed words, write FSM, address counter.
// INSTR_ENC_CHECK_EN adds a sticky ow_err for malformed requests.
module instr_enc
  import instr_enc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  input  logic                 iw_start,
  input  logic [SIZE_ADDR-1:0] iw_base_addr,
  input  logic                 iw_valid,
  output logic                 ow_ready,
  input  logic [SIZE_OPC-1:0]  iw_opc,
  input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic [SIZE_SRC_GP-1:0] iw_src_gp,
  input  logic [SIZE_SRC_SR-1:0] iw_src_sr,
  input  logic [SIZE_CC-1:0]   iw_cc,
  input  logic [SIZE_DATA-1:0] iw_imm,
  input  logic [SIZE_IMMSR-1:0] iw_immsr,
  output logic                 ow_wr_en,
  output logic [SIZE_ADDR-1:0] ow_wr_addr,
  output logic [SIZE_DATA-1:0] ow_wr_data,
  input  logic                 iw_wr_ready,
  output logic                 ow_busy
`ifdef INSTR_ENC_CHECK_EN
  ,
  output logic                 ow_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  enc_req_t req;
  enc_ent_t ent, head;

  assign req = '{opc: iw_opc, tgt_gp: iw_tgt_gp, tgt_sr: iw_tgt_sr, src_gp: iw_src_gp,
                 src_sr: iw_src_sr, cc: iw_cc, imm: iw_imm, immsr: iw_immsr};

`ifdef INSTR_ENC_CHECK_EN
  logic req_err;
  instr_enc_pack u_pack (.req(req), .ent(ent), .err(req_err));
`else
  instr_enc_pack u_pack (.req(req), .ent(ent));
`endif

  enc_ent_t      fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  enc_st_e       st;
  logic [SIZE_DATA-1:0] hold_word;
  logic empty, full, wr_done, pop, push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign wr_done = ow_wr_en && iw_wr_ready;
  assign head    = fifo_q[rd_ptr];
  // MAIN completion pops the next entry in the same edge, so writes stream back to back.
  assign pop     = !iw_start && !empty && ((st == ST_IDLE) || (st == ST_MAIN && wr_done));
  assign ow_ready = !iw_start && (!full || pop);
  assign push    = iw_valid && ow_ready;
  assign ow_busy = !empty || (st != ST_IDLE);

  always_ff @(posedge iw_clk)
    if (push) fifo_q[wr_ptr] <= ent;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (iw_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  enc_st_e              ld_st;
  logic [SIZE_DATA-1:0] ld_data;
  assign ld_st   = head.expand ? ST_LUI : ST_MAIN;
  assign ld_data = head.expand ? head.lui_word : head.word;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      st         <= ST_IDLE;
      ow_wr_en   <= 1'b0;
      ow_wr_addr <= '0;
      ow_wr_data <= '0;
      hold_word  <= '0;
    end else if (iw_start) begin
      st         <= ST_IDLE;
      ow_wr_en   <= 1'b0;
      ow_wr_addr <= iw_base_addr;
      ow_wr_data <= '0;
    end else begin
      case (st)
        ST_IDLE: if (pop) begin
          st         <= ld_st;
          ow_wr_en   <= 1'b1;
          ow_wr_data <= ld_data;
          hold_word  <= head.word;
        end
        ST_LUI: if (wr_done) begin
          st         <= ST_MAIN;
          ow_wr_addr <= ow_wr_addr + SIZE_ADDR'(1);
          ow_wr_data <= hold_word;
        end
        ST_MAIN: if (wr_done) begin
          ow_wr_addr <= ow_wr_addr + SIZE_ADDR'(1);
          if (pop) begin
            st         <= ld_st;
            ow_wr_data <= ld_data;
            hold_word  <= head.word;
          end else begin
            st       <= ST_IDLE;
            ow_wr_en <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

`ifdef INSTR_ENC_CHECK_EN
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst)                ow_err <= 1'b0;
    else if (iw_start)         ow_err <= 1'b0;
    else if (push && req_err)  ow_err <= 1'b1;
  end
`endif

endmodule
